// File: rtl/weighted_rr_packet_arbiter.sv
// Weighted round-robin packet arbiter with wormhole locking and ready handshake.
// Grants are combinational from requests and state; state advances only on accepted flits.
module weighted_rr_packet_arbiter #(
    parameter int unsigned AGENTS_NUM   = 4,
    parameter int unsigned WEIGHT_WIDTH = 4,
    parameter int unsigned PTR_SIZE     = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [AGENTS_NUM-1:0]                requests_i,
    input  logic [AGENTS_NUM-1:0]                tail_i,
    input  logic [AGENTS_NUM*WEIGHT_WIDTH-1:0]   weights_i,
    input  logic                                 ready_i,
    output logic [AGENTS_NUM-1:0]                grants_o,
    output logic                                 grant_valid_o,
    output logic [PTR_SIZE-1:0]                  grant_id_o
);

    localparam int unsigned USED_EXT_W = WEIGHT_WIDTH + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [PTR_SIZE-1:0]     ptr_q, ptr_d;
    logic [PTR_SIZE-1:0]     owner_q, owner_d;
    logic [WEIGHT_WIDTH-1:0] used_q, used_d;

    logic                    win_valid_c;
    logic [PTR_SIZE-1:0]     win_id_c;
    logic [31:0]             scan_idx_c;
    logic [WEIGHT_WIDTH-1:0] weight_c;
    logic [WEIGHT_WIDTH-1:0] quota_c;
    logic [USED_EXT_W-1:0]   used_inc_c;
    logic [PTR_SIZE-1:0]     ptr_next_c;
    logic                    xfer_c;

    // Winner: locked owner only, else first requester scanning from ptr.
    always_comb begin
        win_valid_c = 1'b0;
        win_id_c    = '0;
        scan_idx_c  = '0;
        if (state_q == ST_LOCKED) begin
            win_valid_c = requests_i[owner_q];
            win_id_c    = owner_q;
        end else begin
            for (int unsigned i = 0; i < AGENTS_NUM; i++) begin
                scan_idx_c = 32'(ptr_q) + i;
                if (scan_idx_c >= AGENTS_NUM) begin
                    scan_idx_c = scan_idx_c - AGENTS_NUM;
                end
                if (!win_valid_c && requests_i[PTR_SIZE'(scan_idx_c)]) begin
                    win_valid_c = 1'b1;
                    win_id_c    = PTR_SIZE'(scan_idx_c);
                end
            end
        end
    end

    // Quota of the current priority agent; a zero weight counts as one packet.
    always_comb begin
        weight_c = '0;
        for (int unsigned k = 0; k < AGENTS_NUM; k++) begin
            if (PTR_SIZE'(k) == ptr_q) begin
                weight_c = weights_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
        quota_c    = (weight_c == '0) ? WEIGHT_WIDTH'(1) : weight_c;
        used_inc_c = {1'b0, used_q} + USED_EXT_W'(1);
        ptr_next_c = (win_id_c == PTR_SIZE'(AGENTS_NUM - 1)) ? '0 : win_id_c + PTR_SIZE'(1);
    end

    assign xfer_c = win_valid_c & ready_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        used_d  = used_q;
        if (xfer_c) begin
            if (!tail_i[win_id_c]) begin
                state_d = ST_LOCKED;
                owner_d = win_id_c;
            end else begin
                state_d = ST_IDLE;
                if ((win_id_c == ptr_q) && (used_inc_c < {1'b0, quota_c})) begin
                    used_d = used_inc_c[WEIGHT_WIDTH-1:0];
                end else begin
                    ptr_d  = ptr_next_c;
                    used_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            used_q  <= used_d;
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        grants_o      = '0;
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        if (rst && win_valid_c) begin
            grants_o[win_id_c] = 1'b1;
            grant_valid_o      = 1'b1;
            grant_id_o         = win_id_c;
        end
    end

endmodule
